// File: rtl/spike_encoder.sv
// spike_encoder: latches one vector of per-input spike times and replays it
// across a gamma cycle as one-cycle active-low pulses, reporting the current
// tick, an end-of-gamma pulse and the number of spikes emitted per gamma.

`ifndef NUM_SPIKES
`define NUM_SPIKES 4
`endif

// One spike line: holds its latched spike time and flags a match against the
// tick being entered. On load the incoming time is compared directly so that
// tick-0 spikes appear on the first RUN cycle.
module spike_lane #(
  parameter int TIME_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [TIME_BITS-1:0] load_time,
  input  logic [TIME_BITS-1:0] cmp_tick,
  output logic                 hit
);
  logic [TIME_BITS-1:0] t_q;

  // latched spike time for this line
  always_ff @(posedge clk) begin
    if (rst)       t_q <= '0;
    else if (load) t_q <= load_time;
  end

  assign hit = load ? (load_time == cmp_tick) : (t_q == cmp_tick);
endmodule

module spike_encoder #(
  parameter int NUM_INPUTS = `NUM_SPIKES,
  parameter int TIME_BITS  = 4,
  parameter int GAMMA_LEN  = 8,
  parameter int CNT_BITS   = $clog2(NUM_INPUTS + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [NUM_INPUTS*TIME_BITS-1:0] spike_times,
  output logic                            ready,
  output logic                            busy,
  output logic [TIME_BITS-1:0]            tick,
  output logic [NUM_INPUTS-1:0]           should_spike_in_l,
  output logic                            gamma_done,
  output logic [CNT_BITS-1:0]             spike_count
);
  localparam logic [TIME_BITS-1:0] LAST = TIME_BITS'(GAMMA_LEN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state, state_nxt;
  logic                  last, accept;
  logic [TIME_BITS-1:0]  cmp_tick;
  logic [NUM_INPUTS-1:0] hits;
  logic [CNT_BITS-1:0]   hit_cnt, run_cnt;

  // ready/busy come straight from registered state, no input paths
  assign last  = (state == RUN) && (tick == LAST);
  assign busy  = (state == RUN);
  assign ready = (state == IDLE) || last;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state, acceptance and the tick that the next cycle will show
  always_comb begin
    state_nxt = state;
    accept    = start && ready;
    cmp_tick  = accept ? '0 : tick + TIME_BITS'(1);
    case (state)
      IDLE: if (start)         state_nxt = RUN;
      RUN:  if (last && !start) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // per-line time registers and match logic
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    spike_lane #(.TIME_BITS(TIME_BITS)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .load      (accept),
      .load_time (spike_times[i*TIME_BITS +: TIME_BITS]),
      .cmp_tick  (cmp_tick),
      .hit       (hits[i])
    );
  end

  // number of lines spiking on the tick being entered
  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < NUM_INPUTS; i++) hit_cnt = hit_cnt + CNT_BITS'(hits[i]);
  end

  // registered tick, pulses, running count and end-of-gamma count
  always_ff @(posedge clk) begin
    if (rst) begin
      tick              <= '0;
      should_spike_in_l <= '1;
      gamma_done        <= 1'b0;
      spike_count       <= '0;
      run_cnt           <= '0;
    end else begin
      gamma_done <= 1'b0;
      if (accept) begin
        // new gamma (from IDLE or back-to-back on the last tick)
        tick              <= '0;
        should_spike_in_l <= ~hits;
        run_cnt           <= hit_cnt;
      end else if (busy && !last) begin
        tick              <= cmp_tick;
        should_spike_in_l <= ~hits;
        run_cnt           <= run_cnt + hit_cnt;
        if (cmp_tick == LAST) begin
          gamma_done  <= 1'b1;
          spike_count <= run_cnt + hit_cnt;
        end
      end else begin
        // idle or leaving the last tick: lines high, tick holds
        should_spike_in_l <= '1;
      end
    end
  end
endmodule

// File: tb/tb_spike_encoder.sv
// Bench for spike_encoder: a timeline model (gamma start cycle + latched times)
// is checked against the DUT every cycle, plus directed literal expectations.
module tb_spike_encoder;
  localparam int N  = 4;
  localparam int TB = 4;
  localparam int G  = 8;
  localparam int CB = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [N*TB-1:0] spike_times;
  logic            ready, busy, gamma_done;
  logic [TB-1:0]   tick;
  logic [N-1:0]    lines;
  logic [CB-1:0]   spike_count;

  int checks = 0;
  int errors = 0;

  spike_encoder #(.NUM_INPUTS(N), .TIME_BITS(TB), .GAMMA_LEN(G), .CNT_BITS(CB)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .spike_times       (spike_times),
    .ready             (ready),
    .busy              (busy),
    .tick              (tick),
    .should_spike_in_l (lines),
    .gamma_done        (gamma_done),
    .spike_count       (spike_count)
  );

  always #5 clk = ~clk;

  // ---------------- model: gamma g0 shows tick t at cycle g0+t ----------------
  int            cyc = 0;
  int            m_g0 = 0;
  bit            m_active = 0;
  bit            m_valid = 0;
  logic [N*TB-1:0] m_times = '0;
  logic [TB-1:0] m_hold = '0;
  logic [CB-1:0] m_count = '0;

  function automatic int nvalid(input logic [N*TB-1:0] v);
    int n = 0;
    for (int i = 0; i < N; i++) if (int'(v[i*TB +: TB]) < G) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    bit run_now, last_now, rdy;
    run_now  = m_active && (cyc - m_g0 < G);
    last_now = run_now && (cyc - m_g0 == G - 1);
    rdy      = !run_now || last_now;
    if (rst) begin
      m_active = 0; m_hold = '0; m_count = '0; m_valid = 1;
    end else begin
      if (last_now) begin
        m_count = CB'(nvalid(m_times));
        m_hold  = TB'(G - 1);
      end
      if (start && rdy) begin
        m_times  = spike_times;
        m_g0     = cyc + 1;
        m_active = 1;
      end
    end
    cyc++;
  end

  // compare every cycle once reset has been seen
  always @(negedge clk) begin
    int t;
    bit run_now, last_now;
    logic [N-1:0] el;
    logic [13:0] exp_v, act_v;
    if (m_valid) begin
      t        = cyc - m_g0;
      run_now  = m_active && (t < G);
      last_now = run_now && (t == G - 1);
      for (int i = 0; i < N; i++)
        el[i] = !(run_now && int'(m_times[i*TB +: TB]) == t);
      exp_v = {run_now, !run_now || last_now, run_now ? TB'(t) : m_hold, el,
               last_now, last_now ? CB'(nvalid(m_times)) : m_count};
      act_v = {busy, ready, tick, lines, gamma_done, spike_count};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model cyc=%0d {busy,ready,tick,lines,gd,cnt} got %h want %h",
                 cyc, act_v, exp_v);
      end
    end
  end

  // ---------------- directed literal checks ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, expv);
    end
  endtask

  // present start for one edge; returns at the negedge after that edge
  task automatic do_start(input logic [N*TB-1:0] t);
    @(negedge clk); start = 1'b1; spike_times = t;
    @(negedge clk); start = 1'b0; spike_times = 16'hFFFF;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; spike_times = '0;
    repeat (3) @(negedge clk);
    chk("reset_vals", {busy, ready, tick, lines, gamma_done, spike_count},
        {1'b0, 1'b1, 4'd0, 4'hF, 1'b0, 3'd0});
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic replay {0,3,7,2}
    do_start({4'd2, 4'd7, 4'd3, 4'd0});
    chk("basic_t0", {busy, tick, lines}, {1'b1, 4'd0, 4'b1110});
    repeat (3) @(negedge clk);
    chk("basic_t3", {tick, lines}, {4'd3, 4'b1101});
    repeat (4) @(negedge clk);
    chk("basic_t7", {tick, lines, gamma_done, spike_count}, {4'd7, 4'b1011, 1'b1, 3'd4});
    @(negedge clk);
    chk("basic_after", {busy, lines, gamma_done, tick}, {1'b0, 4'hF, 1'b0, 4'd7});

    // no-spike encodings {8,15,8,1}
    do_start({4'd1, 4'd8, 4'd15, 4'd8});
    @(negedge clk);
    chk("nospk_t1", lines, 4'b0111);
    repeat (6) @(negedge clk);
    chk("nospk_t7", {gamma_done, spike_count}, {1'b1, 3'd1});
    @(negedge clk);

    // simultaneous spikes, all 5
    do_start(16'h5555);
    repeat (5) @(negedge clk);
    chk("simul_t5", lines, 4'b0000);
    @(negedge clk);
    chk("simul_t6", lines, 4'b1111);
    @(negedge clk);
    chk("simul_t7", spike_count, 3'd4);
    @(negedge clk);

    // ignored start at tick 3, then back-to-back at tick 7
    do_start({4'd2, 4'd7, 4'd3, 4'd0});
    repeat (3) @(negedge clk);
    start = 1'b1; spike_times = 16'h1111;
    @(negedge clk);
    start = 1'b0; spike_times = 16'hFFFF;
    chk("ign_t4", {tick, lines}, {4'd4, 4'hF});
    repeat (3) @(negedge clk);
    chk("b2b_t7", {tick, lines, gamma_done, ready}, {4'd7, 4'b1011, 1'b1, 1'b1});
    start = 1'b1; spike_times = 16'h0000;
    @(negedge clk);
    start = 1'b0; spike_times = 16'hFFFF;
    chk("b2b_t0", {busy, tick, lines}, {1'b1, 4'd0, 4'b0000});
    repeat (7) @(negedge clk);
    chk("b2b_done", {busy, gamma_done, spike_count}, {1'b1, 1'b1, 3'd4});
    @(negedge clk);

    // reset mid-gamma, all 6
    do_start(16'h6666);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid", {busy, ready, tick, lines, gamma_done, spike_count},
        {1'b0, 1'b1, 4'd0, 4'hF, 1'b0, 3'd0});
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("rst_after", {lines, spike_count, busy}, {4'hF, 3'd0, 1'b0});

    // count hold {1,2,3,9}
    do_start({4'd9, 4'd3, 4'd2, 4'd1});
    repeat (7) @(negedge clk);
    chk("hold_t7", {gamma_done, spike_count}, {1'b1, 3'd3});
    repeat (20) @(negedge clk);
    chk("hold_idle", {busy, lines, spike_count}, {1'b0, 4'hF, 3'd3});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
